ex_mem_stage: RTL and testbench

- EX/MEM pipeline stage register directly downstream of the ALU in the 5-stage RISC-V core.
- Captures the ALU result, flags and memory/writeback control, and resolves conditional branches from the ALU flags plus the operand sign bits.
- Issues a one-cycle PC redirect from MEM, squashes the wrong-path instruction behind a taken branch, and exports forwarding data back to EX.

---
 rtl/ex_mem_stage.sv | 120 ++++++++++++
 tb/tb_ex_mem_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with branch resolution, redirect and forwarding
//
// Purpose: registers the ALU result and memory/writeback control for MEM,
// resolves conditional branches from the ALU flags and operand sign bits,
// raises a single-cycle PC redirect for taken branches/jumps, squashes the
// wrong-path instruction arriving from EX, and exports forwarding data.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   ex_*                   instruction, flags and control arriving from EX
//   mem_stall              hold every register (data memory not ready)
//   mem_*                  registered MEM-stage instruction state
//   redirect, redirect_pc  one-cycle PC redirect / upstream flush and target
//   fwd_en, fwd_rd, fwd_data  forwarding source back to EX

module ex_mem_stage #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_alu_out,
   input  logic             ex_zero,
   input  logic             ex_negativo,
   input  logic             ex_a_msb,
   input  logic             ex_b_msb,
   input  logic [XLEN-1:0]  ex_rs2_data,
   input  logic [RADDR-1:0] ex_rd,
   input  logic [2:0]       ex_ctrl,
   input  logic             ex_branch,
   input  logic             ex_jump,
   input  logic [2:0]       ex_funct3,
   input  logic [XLEN-1:0]  ex_target,
   input  logic [XLEN-1:0]  ex_link,
   input  logic             mem_stall,
   output logic             mem_valid,
   output logic [XLEN-1:0]  mem_result,
   output logic [XLEN-1:0]  mem_rs2_data,
   output logic [RADDR-1:0] mem_rd,
   output logic [2:0]       mem_ctrl,
   output logic [2:0]       mem_funct3,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             fwd_en,
   output logic [RADDR-1:0] fwd_rd,
   output logic [XLEN-1:0]  fwd_data
);

   logic slt;
   logic ult;
   logic cond;
   logic taken;
   logic squash;
   logic valid_next;
   logic taken_q;
   logic redir_done;

   // Compare results derived from the subtract result and operand signs.
   // When the signs differ the subtraction may overflow, so the answer comes
   // straight from the sign bits instead of the (possibly wrapped) result.
   always_comb begin
      slt = (ex_a_msb ^ ex_b_msb) ? ex_a_msb : ex_negativo;
      ult = (ex_a_msb ^ ex_b_msb) ? ex_b_msb : ex_negativo;
      cond = 1'b0;
      case (ex_funct3)
         3'b000:  cond = ex_zero;
         3'b001:  cond = ~ex_zero;
         3'b100:  cond = slt;
         3'b101:  cond = ~slt;
         3'b110:  cond = ult;
         3'b111:  cond = ~ult;
         default: cond = 1'b0;
      endcase
   end

   // Jump takes precedence: it is taken whatever cond says.
   assign taken      = ex_valid & (ex_jump | (ex_branch & cond));
   // A taken instruction sitting in MEM means the EX occupant is wrong-path.
   assign squash     = mem_valid & taken_q;
   assign valid_next = ex_valid & ~squash;

   // redir_done masks the redirect for the remaining cycles of a stall so
   // the fetch unit sees exactly one pulse per taken instruction.
   assign redirect = mem_valid & taken_q & ~redir_done;

   // Loads have no data yet at this stage, so they never forward.
   assign fwd_en   = mem_valid & mem_ctrl[2] & (mem_rd != '0) & ~mem_ctrl[1];
   assign fwd_rd   = mem_rd;
   assign fwd_data = mem_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_valid    <= 1'b0;
         mem_result   <= '0;
         mem_rs2_data <= '0;
         mem_rd       <= '0;
         mem_ctrl     <= 3'b000;
         mem_funct3   <= 3'b000;
         redirect_pc  <= '0;
         taken_q      <= 1'b0;
         redir_done   <= 1'b0;
      end else if (mem_stall) begin
         if (redirect) begin
            redir_done <= 1'b1;
         end
      end else begin
         mem_valid    <= valid_next;
         mem_ctrl     <= valid_next ? ex_ctrl : 3'b000;
         taken_q      <= taken & ~squash;
         mem_result   <= ex_jump ? ex_link : ex_alu_out;
         mem_rs2_data <= ex_rs2_data;
         mem_rd       <= ex_rd;
         mem_funct3   <= ex_funct3;
         redirect_pc  <= ex_target;
         redir_done   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage

module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_alu_out;
   logic        ex_zero;
   logic        ex_negativo;
   logic        ex_a_msb;
   logic        ex_b_msb;
   logic [31:0] ex_rs2_data;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_ctrl;
   logic        ex_branch;
   logic        ex_jump;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_target;
   logic [31:0] ex_link;
   logic        mem_stall;
   logic        mem_valid;
   logic [31:0] mem_result;
   logic [31:0] mem_rs2_data;
   logic [4:0]  mem_rd;
   logic [2:0]  mem_ctrl;
   logic [2:0]  mem_funct3;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fwd_en;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
      .ex_zero(ex_zero), .ex_negativo(ex_negativo), .ex_a_msb(ex_a_msb),
      .ex_b_msb(ex_b_msb), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
      .ex_ctrl(ex_ctrl), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_funct3(ex_funct3), .ex_target(ex_target), .ex_link(ex_link),
      .mem_stall(mem_stall), .mem_valid(mem_valid), .mem_result(mem_result),
      .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd), .mem_ctrl(mem_ctrl),
      .mem_funct3(mem_funct3), .redirect(redirect), .redirect_pc(redirect_pc),
      .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic v, input logic br, input logic jp, input logic [2:0] f3,
                            input logic z, input logic neg, input logic am, input logic bm,
                            input logic [2:0] ctrl, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] tgt, input logic [31:0] lnk);
      ex_valid = v; ex_branch = br; ex_jump = jp; ex_funct3 = f3;
      ex_zero = z; ex_negativo = neg; ex_a_msb = am; ex_b_msb = bm;
      ex_ctrl = ctrl; ex_rd = rd; ex_alu_out = alu; ex_target = tgt; ex_link = lnk;
      ex_rs2_data = alu ^ 32'hA5A5_0000;
   endtask

   task automatic bubble();
      set_instr(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; mem_stall = 1'b0;
      bubble();
      step(); step();
      chk("rst_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst_result", mem_result, 32'h0);
      chk("rst_ctrl", {29'b0, mem_ctrl}, 32'd0);
      chk("rst_redirect", {31'b0, redirect}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      chk("rst_fwd_en", {31'b0, fwd_en}, 32'd0);
      rst = 1'b0;

      // BEQ taken
      set_instr(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h100, 32'h0);
      step();
      chk("beq_valid", {31'b0, mem_valid}, 32'd1);
      chk("beq_redirect", {31'b0, redirect}, 32'd1);
      chk("beq_redirect_pc", redirect_pc, 32'h100);
      // wrong-path instruction is squashed
      set_instr(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 5'd5, 32'h55, 32'h0, 32'h0);
      step();
      chk("squash_valid", {31'b0, mem_valid}, 32'd0);
      chk("squash_ctrl", {29'b0, mem_ctrl}, 32'd0);
      chk("squash_redirect", {31'b0, redirect}, 32'd0);
      chk("squash_fwd_en", {31'b0, fwd_en}, 32'd0);
      step();
      chk("alu_valid", {31'b0, mem_valid}, 32'd1);
      chk("alu_ctrl", {29'b0, mem_ctrl}, 32'd4);
      chk("alu_fwd_en", {31'b0, fwd_en}, 32'd1);
      chk("alu_fwd_rd", {27'b0, fwd_rd}, 32'd5);
      chk("alu_fwd_data", fwd_data, 32'h55);
      chk("alu_rs2", mem_rs2_data, 32'hA5A5_0055);
      chk("alu_redirect", {31'b0, redirect}, 32'd0);

      // BLT 0x80000000 < 1 signed: taken
      set_instr(1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd0, 32'h8000_0001, 32'h140, 32'h0);
      step();
      chk("blt_redirect", {31'b0, redirect}, 32'd1);
      chk("blt_funct3", {29'b0, mem_funct3}, 32'd4);
      bubble(); step();
      chk("blt_shadow_valid", {31'b0, mem_valid}, 32'd0);
      // BLTU same operands: not taken
      set_instr(1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd0, 32'h8000_0001, 32'h180, 32'h0);
      step();
      chk("bltu_nt_valid", {31'b0, mem_valid}, 32'd1);
      chk("bltu_nt_redirect", {31'b0, redirect}, 32'd0);

      // BGEU 1 >= 0xFFFFFFFF unsigned: not taken
      set_instr(1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 5'd0, 32'h2, 32'h1C0, 32'h0);
      step();
      chk("bgeu_valid", {31'b0, mem_valid}, 32'd1);
      chk("bgeu_redirect", {31'b0, redirect}, 32'd0);
      // BLTU same operands: taken
      set_instr(1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 5'd0, 32'h2, 32'h1E0, 32'h0);
      step();
      chk("bltu_t_redirect", {31'b0, redirect}, 32'd1);
      chk("bltu_t_pc", redirect_pc, 32'h1E0);
      bubble(); step();

      // funct3 010 never takes a branch
      set_instr(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 5'd0, 32'h0, 32'h1F0, 32'h0);
      step();
      chk("f3_010_redirect", {31'b0, redirect}, 32'd0);

      // Taken branch then a 3-cycle stall
      set_instr(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd3, 32'h77, 32'h300, 32'h0);
      step();
      chk("stall_first_redirect", {31'b0, redirect}, 32'd1);
      mem_stall = 1'b1;
      set_instr(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 5'd9, 32'h99, 32'h999, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_redirect", {31'b0, redirect}, 32'd0);
         chk("stall_valid", {31'b0, mem_valid}, 32'd1);
         chk("stall_result", mem_result, 32'h77);
         chk("stall_pc", redirect_pc, 32'h300);
         chk("stall_rd", {27'b0, mem_rd}, 32'd3);
      end
      mem_stall = 1'b0;
      step();
      chk("post_stall_valid", {31'b0, mem_valid}, 32'd0);
      chk("post_stall_redirect", {31'b0, redirect}, 32'd0);

      // JAL rd=1
      set_instr(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 5'd1, 32'h999, 32'h200, 32'h44);
      step();
      chk("jal_result", mem_result, 32'h44);
      chk("jal_pc", redirect_pc, 32'h200);
      chk("jal_redirect", {31'b0, redirect}, 32'd1);
      chk("jal_fwd_en", {31'b0, fwd_en}, 32'd1);
      chk("jal_fwd_data", fwd_data, 32'h44);
      bubble(); step();
      // JAL rd=0
      set_instr(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 5'd0, 32'h999, 32'h200, 32'h44);
      step();
      chk("jal_x0_valid", {31'b0, mem_valid}, 32'd1);
      chk("jal_x0_fwd_en", {31'b0, fwd_en}, 32'd0);
      bubble(); step();
      // Load
      set_instr(1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 5'd2, 32'h1000, 32'h0, 32'h0);
      step();
      chk("load_valid", {31'b0, mem_valid}, 32'd1);
      chk("load_ctrl", {29'b0, mem_ctrl}, 32'd6);
      chk("load_fwd_en", {31'b0, fwd_en}, 32'd0);

      // Reset while a taken branch is held by a stall
      set_instr(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 5'd7, 32'h0, 32'h400, 32'h0);
      step();
      chk("pre_rst_redirect", {31'b0, redirect}, 32'd1);
      mem_stall = 1'b1; rst = 1'b1;
      step();
      chk("rst2_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst2_redirect", {31'b0, redirect}, 32'd0);
      chk("rst2_pc", redirect_pc, 32'h0);
      chk("rst2_ctrl", {29'b0, mem_ctrl}, 32'd0);
      chk("rst2_rd", {27'b0, mem_rd}, 32'd0);
      rst = 1'b0; mem_stall = 1'b0;
      set_instr(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 5'd6, 32'h66, 32'h0, 32'h0);
      step();
      chk("after_rst_valid", {31'b0, mem_valid}, 32'd1);
      chk("after_rst_result", mem_result, 32'h66);
      chk("after_rst_fwd_en", {31'b0, fwd_en}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
